// File: rtl/rv523_cell_pkg.sv
// Shared helpers for RV523 cell-library blocks: pointer sizing and parameter legality check.
`ifndef RV523_CELL_PKG_SV
`define RV523_CELL_PKG_SV

// Elaboration-time legality check for FIFO parameters; expands to a generate-if that
// raises an elaboration error when any constraint is violated.
`define RV523_FIFO_PARAM_CHECK(WIDTH_, DEPTH_, AF_, AE_) \
  if (((WIDTH_) < 1) || ((DEPTH_) < 2) || ((((DEPTH_) & ((DEPTH_) - 1))) != 0) || \
      ((AF_) < 1) || ((AF_) > (DEPTH_)) || ((AE_) > ((DEPTH_) - 1))) begin : g_param_err \
    $error("cell_fifo: illegal WIDTH/DEPTH/AF_LEVEL/AE_LEVEL combination"); \
  end

package rv523_cell_pkg;

  // Pointer width: index bits plus one wrap bit.
  function automatic int unsigned ptr_width(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

`endif

// File: rtl/cell_fifo_if.sv
// Handshake and status bundle for cell_fifo; master drives requests, slave is the FIFO.
interface cell_fifo_if
  import rv523_cell_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
);
  localparam int unsigned CntW = ptr_width(DEPTH);

  logic             wr_en;
  logic [WIDTH-1:0] wr_data;
  logic             rd_en;
  logic [WIDTH-1:0] rd_data;
  logic             full;
  logic             empty;
  logic             almost_full;
  logic             almost_empty;
  logic [CntW-1:0]  count;
  logic             ovf;
  logic             udf;

  modport master (
    output wr_en, wr_data, rd_en,
    input  rd_data, full, empty, almost_full, almost_empty, count, ovf, udf
  );

  modport slave (
    input  wr_en, wr_data, rd_en,
    output rd_data, full, empty, almost_full, almost_empty, count, ovf, udf
  );
endinterface

// File: rtl/dff_cell.sv
// WIDTH-bit rising-edge register with write enable, built as a master/slave latch pair.
module dff_cell #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             en_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);
  logic             clk_n;
  logic [WIDTH-1:0] m_d_q;
  logic             m_en_q;

  // Inverter cell producing the master latch's enable.
  assign clk_n = ~clk_i;

  // Master latch: tracks data and enable while the clock is low, freezes at the rising edge.
  always_latch begin
    if (clk_n) begin
      m_d_q  <= d_i;
      m_en_q <= en_i;
    end
  end

  // Slave latch: opens during the high phase, but only if the frozen enable was set.
  always_latch begin
    if (clk_i && m_en_q) begin
      q_o <= m_d_q;
    end
  end
endmodule

// File: rtl/cell_fifo.sv
// First-word-fall-through FIFO over dff_cell storage with occupancy, threshold and sticky
// error flags.
module cell_fifo
  import rv523_cell_pkg::*;
#(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned AF_LEVEL = DEPTH - 1,
  parameter int unsigned AE_LEVEL = 1
) (
  input logic        clk,
  input logic        rst,
  cell_fifo_if.slave bus
);
  localparam int unsigned PtrW = ptr_width(DEPTH);
  localparam int unsigned IdxW = PtrW - 1;
  localparam logic [PtrW-1:0] AfLvl = PtrW'(AF_LEVEL);
  localparam logic [PtrW-1:0] AeLvl = PtrW'(AE_LEVEL);

  `RV523_FIFO_PARAM_CHECK(WIDTH, DEPTH, AF_LEVEL, AE_LEVEL)

  logic [PtrW-1:0]  wp_q, wp_d;
  logic [PtrW-1:0]  rp_q, rp_d;
  logic             ovf_q, ovf_d;
  logic             udf_q, udf_d;

  logic [PtrW-1:0]  count;
  logic [IdxW-1:0]  wp_idx, rp_idx;
  logic             full, empty;
  logic             push_ok, pop_ok;
  logic [DEPTH-1:0] cell_we;
  logic [WIDTH-1:0] mem [DEPTH];

  // Occupancy and full/empty derived purely from the pointer registers.
  always_comb begin
    wp_idx  = wp_q[IdxW-1:0];
    rp_idx  = rp_q[IdxW-1:0];
    count   = wp_q - rp_q;
    empty   = (wp_q == rp_q);
    full    = (wp_idx == rp_idx) && (wp_q[PtrW-1] != rp_q[PtrW-1]);
    // A push is refused whenever full, even if a pop happens in the same cycle.
    push_ok = bus.wr_en && !full;
    pop_ok  = bus.rd_en && !empty;
  end

  // Pointer advance and sticky error capture.
  always_comb begin
    wp_d  = wp_q;
    rp_d  = rp_q;
    ovf_d = ovf_q;
    udf_d = udf_q;
    if (push_ok) wp_d = wp_q + PtrW'(1);
    if (pop_ok) rp_d = rp_q + PtrW'(1);
    if (bus.wr_en && full) ovf_d = 1'b1;
    if (bus.rd_en && empty) udf_d = 1'b1;
  end

  // Control state register with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp_q  <= '0;
      rp_q  <= '0;
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      wp_q  <= wp_d;
      rp_q  <= rp_d;
      ovf_q <= ovf_d;
      udf_q <= udf_d;
    end
  end

  // One-hot write enable steering the accepted push to the cell under the write index.
  always_comb begin
    cell_we = '0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      cell_we[i] = push_ok && (wp_idx == IdxW'(i));
    end
  end

  // Storage cells are left unreset; RD_DATA gating hides stale contents.
  for (genvar g = 0; g < int'(DEPTH); g++) begin : g_cell
    dff_cell #(
      .WIDTH(WIDTH)
    ) u_cell (
      .clk_i(clk),
      .en_i (cell_we[g]),
      .d_i  (bus.wr_data),
      .q_o  (mem[g])
    );
  end

  // Outputs depend on state only; head word is forced to zero while empty.
  always_comb begin
    bus.rd_data      = empty ? '0 : mem[rp_idx];
    bus.full         = full;
    bus.empty        = empty;
    bus.almost_full  = (count >= AfLvl);
    bus.almost_empty = (count <= AeLvl);
    bus.count        = count;
    bus.ovf          = ovf_q;
    bus.udf          = udf_q;
  end
endmodule

// File: tb/tb_cell_fifo.sv
// Self-checking bench for cell_fifo: directed scenarios plus random traffic against a queue model.
module tb_cell_fifo;
  localparam int unsigned W  = 8;
  localparam int unsigned D  = 4;
  localparam int unsigned AF = 3;
  localparam int unsigned AE = 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  cell_fifo_if #(.WIDTH(W), .DEPTH(D)) bus ();

  cell_fifo #(
    .WIDTH   (W),
    .DEPTH   (D),
    .AF_LEVEL(AF),
    .AE_LEVEL(AE)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int checks   = 0;
  int failures = 0;

  // Reference model: a plain queue of accepted words plus sticky error bits.
  logic [W-1:0] mq[$];
  logic         m_ovf = 1'b0;
  logic         m_udf = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_state(input string tag);
    int unsigned  n;
    logic [W-1:0] head;
    n    = mq.size();
    head = (n == 0) ? '0 : mq[0];
    chk({tag, ".count"}, 32'(bus.count), n);
    chk({tag, ".empty"}, 32'(bus.empty), 32'(n == 0));
    chk({tag, ".full"}, 32'(bus.full), 32'(n == D));
    chk({tag, ".almost_full"}, 32'(bus.almost_full), 32'(n >= AF));
    chk({tag, ".almost_empty"}, 32'(bus.almost_empty), 32'(n <= AE));
    chk({tag, ".ovf"}, 32'(bus.ovf), 32'(m_ovf));
    chk({tag, ".udf"}, 32'(bus.udf), 32'(m_udf));
    chk({tag, ".rd_data"}, 32'(bus.rd_data), 32'(head));
  endtask

  task automatic model_reset();
    mq.delete();
    m_ovf = 1'b0;
    m_udf = 1'b0;
  endtask

  // Called from the negedge phase: drive, take one rising edge, update model, check at negedge.
  task automatic step(input string tag, input logic wr, input logic [W-1:0] data, input logic rd);
    int unsigned n;
    bus.wr_en   = wr;
    bus.wr_data = data;
    bus.rd_en   = rd;
    @(posedge clk);
    n = mq.size();
    if (rd) begin
      if (n == 0) m_udf = 1'b1;
      else void'(mq.pop_front());
    end
    if (wr) begin
      if (n == D) m_ovf = 1'b1;
      else mq.push_back(data);
    end
    @(negedge clk);
    check_state(tag);
  endtask

  logic [W-1:0] vals[4];

  initial begin
    bus.wr_en   = 1'b0;
    bus.wr_data = '0;
    bus.rd_en   = 1'b0;
    vals[0] = 8'h11; vals[1] = 8'h22; vals[2] = 8'h33; vals[3] = 8'h44;

    repeat (2) @(negedge clk);
    check_state("in_reset");
    rst = 1'b0;
    @(negedge clk);
    check_state("idle");

    // Fill, then drain, watching thresholds and FWFT order.
    for (int i = 0; i < 4; i++) step("fill", 1'b1, vals[i], 1'b0);
    for (int i = 0; i < 4; i++) step("drain", 1'b0, '0, 1'b1);

    // Simultaneous push/pop while full: pop wins, push is dropped, OVF sticks.
    for (int i = 0; i < 4; i++) step("refill", 1'b1, vals[i], 1'b0);
    step("full_both", 1'b1, 8'h55, 1'b1);
    for (int i = 0; i < 3; i++) step("drain2", 1'b0, '0, 1'b1);

    // Simultaneous push/pop while empty: push wins, UDF sticks.
    step("empty_both", 1'b1, 8'hA5, 1'b1);

    // Hold occupancy at 2 across the pointer wrap.
    step("to_two", 1'b1, 8'hB1, 1'b0);
    for (int i = 0; i < 10; i++) step("wrap", 1'b1, 8'(8'hC0 + i), 1'b1);

    // Asynchronous reset in the middle of a cycle with three entries queued.
    step("to_three", 1'b1, 8'hD3, 1'b0);
    bus.wr_en = 1'b0;
    #2 rst = 1'b1;
    model_reset();
    #1 check_state("async_rst");
    @(negedge clk);
    rst = 1'b0;
    step("post_rst", 1'b1, 8'h7E, 1'b0);

    // Random traffic with shifting push/pop bias to visit full and empty regularly.
    for (int i = 0; i < 400; i++) begin
      int unsigned bias;
      logic        wr;
      logic        rd;
      bias = (i / 50) % 3;
      wr   = ($urandom_range(0, 3) < ((bias == 0) ? 3 : (bias == 1) ? 1 : 2));
      rd   = ($urandom_range(0, 3) < ((bias == 0) ? 1 : (bias == 1) ? 3 : 2));
      step("random", wr, 8'($urandom), rd);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
